adder_arbiter: RTL and testbench



---
 rtl/adder_arb_pkg.sv | 16 +
 rtl/adder_core.sv | 26 ++
 rtl/adder_arbiter.sv | 144 ++++++++++++++
 tb/tb_adder_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int W_ADD = 4;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/adder_core.sv
// Combinational 4-bit ripple-carry adder: one half adder followed by three full adders.
module adder_core
    import adder_arb_pkg::*;
(
    input  logic [W_ADD-1:0] a_i,
    input  logic [W_ADD-1:0] b_i,
    output logic [W_ADD:0]   sum_o
);

    logic [W_ADD-1:0] s;
    logic             carry;

    // Carry is rippled procedurally so no vector feeds back into itself.
    always_comb begin
        s     = '0;
        s[0]  = a_i[0] ^ b_i[0];
        carry = a_i[0] & b_i[0];
        for (int i = 1; i < W_ADD; i++) begin
            s[i]  = a_i[i] ^ b_i[i] ^ carry;
            carry = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
    end

    assign sum_o = {carry, s};

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 4-bit adder between NREQ requesters.
// Define ADDER_ARB_STATS_EN to add the saturating busy-cycle counter busy_cnt.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W:0]        res_sum,
    output logic [IDW-1:0]    res_id
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [7:0]        busy_cnt
`endif
);

    if (W != W_ADD) begin : g_bad_w
        $error("adder_arbiter: W must equal the shared adder width");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("adder_arbiter: NREQ must be in 2..8");
    end

    state_t        state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic [IDW-1:0] op_id_q, op_id_d;
    logic          res_valid_q, res_valid_d;
    logic [W:0]    res_sum_q, res_sum_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic [W:0]    core_sum;
    logic          grant_vld;
    logic [IDW-1:0] grant_idx;

    adder_core u_adder_core (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (core_sum)
    );

    // Scan downward in offset so the requester closest to rr_ptr wins.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                if (ena && rst_n && grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    op_a_d   = req_a[int'(grant_idx)*W +: W];
                    op_b_d   = req_b[int'(grant_idx)*W +: W];
                    op_id_d  = grant_idx;
                    rr_ptr_d = IDW'(rr_next(int'(grant_idx), NREQ));
                    state_d  = CALC;
                end
            end
            CALC: begin
                res_sum_d   = core_sum;
                res_id_d    = op_id_q;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
        end else if (ena) begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;

`ifdef ADDER_ARB_STATS_EN
    logic [7:0] busy_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt_q <= '0;
        end else if (ena && state_q != IDLE && busy_cnt_q != 8'hFF) begin
            busy_cnt_q <= busy_cnt_q + 8'd1;
        end
    end

    assign busy_cnt = busy_cnt_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter; the stats test runs when ADDER_ARB_STATS_EN is defined.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [W:0]        res_sum;
    logic [IDW-1:0]    res_id;
`ifdef ADDER_ARB_STATS_EN
    logic [7:0]        busy_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        int id;
        int sum;
    } exp_t;
    exp_t sbq[$];

    adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id)
`ifdef ADDER_ARB_STATS_EN
        ,
        .busy_cnt  (busy_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = 4'(a);
        req_b[i*W +: W] = 4'(b);
    endtask

    task automatic push_exp(input int id, input int sum);
        exp_t e;
        e.id  = id;
        e.sum = sum;
        sbq.push_back(e);
    endtask

    task automatic wait_res(output bit got, input int limit);
        got = 1'b0;
        for (int n = 0; n < limit && !got; n++) begin
            if (res_valid === 1'b1) got = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset();
        bit   got;
        exp_t e;
        rst_n = 1'b0; ena = 1'b1; res_ready = 1'b1; req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_op(i, i, i);
        for (int c = 0; c < 2; c++) begin
            step();
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
            total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
            total++; if (res_sum !== 5'd0) begin bad++; $display("FAIL reset_sum: got %0d expected 0", res_sum); end
            total++; if (res_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d expected 0", res_id); end
        end
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready); end
        push_exp(0, 0);
        step();
        req_valid = '0;
        wait_res(got, 6);
        total++;
        if (!got || sbq.size() == 0) begin
            bad++; $display("FAIL reset_result: got no result expected id=0 sum=0");
        end else begin
            e = sbq.pop_front();
            if (res_sum !== 5'(e.sum) || res_id !== 2'(e.id)) begin
                bad++; $display("FAIL reset_result: got id=%0d sum=%0d expected id=%0d sum=%0d", res_id, res_sum, e.id, e.sum);
            end
        end
        step();
    endtask

    task automatic test_single();
        exp_t e;
        set_op(2, 15, 1);
        req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
        push_exp(2, 15 + 1);
        step();
        req_valid = '0;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_pulse: got %b expected 0000", req_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b expected 0", res_valid); end
        step();
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL single_latency: got %b expected 1", res_valid); end
        total++;
        if (sbq.size() == 0) begin
            bad++; $display("FAIL single_result: got empty scoreboard expected one entry");
        end else begin
            e = sbq.pop_front();
            if (res_sum !== 5'(e.sum) || res_id !== 2'(e.id)) begin
                bad++; $display("FAIL single_result: got id=%0d sum=%0h expected id=%0d sum=%0h", res_id, res_sum, e.id, e.sum);
            end
        end
        step();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_valid_pulse: got %b expected 0", res_valid); end
    endtask

    task automatic test_round_robin();
        int            exp_id = 0;
        int            last   = -1;
        int            popped = 0;
        int            cyc    = 0;
        logic [NREQ-1:0] oh;
        exp_t          e;
        rst_n = 1'b0; req_valid = '0; res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, i, i);
        step();
        rst_n = 1'b1;
        req_valid = '1;
        #1;
        while (popped < 5 && cyc < 40) begin
            if (res_valid === 1'b1) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++; $display("FAIL rr_result: got unexpected result id=%0d expected none", res_id);
                end else begin
                    e = sbq.pop_front();
                    if (res_sum !== 5'(e.sum) || res_id !== 2'(e.id)) begin
                        bad++; $display("FAIL rr_result: got id=%0d sum=%0d expected id=%0d sum=%0d", res_id, res_sum, e.id, e.sum);
                    end
                end
                popped++;
            end
            if (req_ready !== 4'b0000) begin
                oh = '0;
                oh[exp_id] = 1'b1;
                total++; if (req_ready !== oh) begin bad++; $display("FAIL rr_grant: got %b expected %b", req_ready, oh); end
                if (last >= 0) begin
                    total++; if (cyc - last != 3) begin bad++; $display("FAIL rr_gap: got %0d expected 3", cyc - last); end
                end
                last = cyc;
                push_exp(exp_id, 2 * exp_id);
                exp_id = (exp_id + 1) % NREQ;
            end
            if (popped == 5) req_valid = '0;
            step();
            cyc++;
        end
        total++; if (popped != 5) begin bad++; $display("FAIL rr_timeout: got %0d results expected 5", popped); end
        req_valid = '0;
        sbq.delete();
        step();
    endtask

    task automatic test_back_pressure();
        exp_t e;
        set_op(1, 7, 9);
        res_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant: got %b expected 0010", req_ready); end
        push_exp(1, 16);
        step();
        req_valid = '0;
        step();
        req_valid = '1;
        #1;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (res_valid !== 1'b1 || res_sum !== 5'd16 || res_id !== 2'd1 || req_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_hold: got valid=%b sum=%0d id=%0d ready=%b expected 1/16/1/0000", res_valid, res_sum, res_id, req_ready);
            end
            step();
        end
        res_ready = 1'b1;
        #1;
        total++;
        if (sbq.size() == 0 || res_valid !== 1'b1) begin
            bad++; $display("FAIL bp_result: got valid=%b expected 1 with pending entry", res_valid);
        end else begin
            e = sbq.pop_front();
            if (res_sum !== 5'(e.sum) || res_id !== 2'(e.id)) begin
                bad++; $display("FAIL bp_result: got id=%0d sum=%0d expected id=%0d sum=%0d", res_id, res_sum, e.id, e.sum);
            end
        end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_same_cycle_grant: got %b expected 0000", req_ready); end
        step();
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_resume: got %b expected 0100", req_ready); end
        req_valid = '0;
        step();
    endtask

    task automatic test_midop_reset_ena();
        exp_t e;
        set_op(0, 5, 6);
        req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_grant: got %b expected 0001", req_ready); end
        step();
        req_valid = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_drop: got %b expected 0", res_valid); end
            step();
        end
        req_valid = '1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_rr_reset: got %b expected 0001", req_ready); end
        push_exp(0, 11);
        step();
        req_valid = '0;
        step();
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL ena_pre_valid: got %b expected 1", res_valid); end
        ena = 1'b0;
        res_ready = 1'b1;
        req_valid = '1;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL ena_ready_low: got %b expected 0000", req_ready); end
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (res_valid !== 1'b1 || res_sum !== 5'd11 || res_id !== 2'd0 || req_ready !== 4'b0000) begin
                bad++; $display("FAIL ena_hold: got valid=%b sum=%0d id=%0d ready=%b expected 1/11/0/0000", res_valid, res_sum, res_id, req_ready);
            end
        end
        ena = 1'b1;
        req_valid = '0;
        #1;
        total++;
        if (sbq.size() == 0) begin
            bad++; $display("FAIL ena_result: got empty scoreboard expected one entry");
        end else begin
            e = sbq.pop_front();
            if (res_sum !== 5'(e.sum) || res_id !== 2'(e.id)) begin
                bad++; $display("FAIL ena_result: got id=%0d sum=%0d expected id=%0d sum=%0d", res_id, res_sum, e.id, e.sum);
            end
        end
        step();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL ena_release: got %b expected 0", res_valid); end
    endtask

`ifdef ADDER_ARB_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0; ena = 1'b1; res_ready = 1'b1; req_valid = '0;
        step();
        total++; if (busy_cnt !== 8'd0) begin bad++; $display("FAIL stats_reset: got %0d expected 0", busy_cnt); end
        rst_n = 1'b1;
        req_valid = '1;
        #1;
        for (int c = 0; c <= 600; c++) begin
            if (c == 150) begin
                total++; if (busy_cnt !== 8'd100) begin bad++; $display("FAIL stats_mid: got %0d expected 100", busy_cnt); end
            end
            if (c == 382) begin
                total++; if (busy_cnt !== 8'd254) begin bad++; $display("FAIL stats_pre_sat: got %0d expected 254", busy_cnt); end
            end
            if (c == 384) begin
                total++; if (busy_cnt !== 8'd255) begin bad++; $display("FAIL stats_sat: got %0d expected 255", busy_cnt); end
            end
            if (c == 600) begin
                total++; if (busy_cnt !== 8'd255) begin bad++; $display("FAIL stats_no_wrap: got %0d expected 255", busy_cnt); end
            end
            if (c < 600) step();
        end
        req_valid = '0;
        step();
    endtask
`endif

    initial begin
        rst_n = 1'b0; ena = 1'b1; res_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_midop_reset_ena();
`ifdef ADDER_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
